// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-port SRAM arbiter.
// RET_DEPTH is the grant-to-data distance of a read (issue stage plus SRAM latency).
package sram_arb_pkg;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_id_t;

    localparam int RD_LAT    = 1;
    localparam int RET_DEPTH = RD_LAT + 1;

    typedef struct packed {
        logic     valid;
        port_id_t port;
    } ret_entry_t;

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Requester handshakes and SRAM bus shared by the arbiter and its environment.
// The arbiter takes the slave view; requesters and the SRAM macro take the master view.
interface sram_port_arbiter_if
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) ();

    logic              a_req_i;
    logic              a_we_i;
    logic [ADDR_W-1:0] a_addr_i;
    logic [DATA_W-1:0] a_wdata_i;
    logic              a_ack_o;
    logic [DATA_W-1:0] a_rdata_o;

    logic              b_req_i;
    logic              b_we_i;
    logic [ADDR_W-1:0] b_addr_i;
    logic [DATA_W-1:0] b_wdata_i;
    logic              b_ack_o;
    logic [DATA_W-1:0] b_rdata_o;

    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_data_o;
    logic              mem_wr_o;
    logic [DATA_W-1:0] mem_data_i;

    // Round-robin pointer, exposed for debug observability.
    port_id_t          last_grant_o;

    modport slave (
        input  a_req_i, a_we_i, a_addr_i, a_wdata_i,
        input  b_req_i, b_we_i, b_addr_i, b_wdata_i,
        input  mem_data_i,
        output a_ack_o, a_rdata_o, b_ack_o, b_rdata_o,
        output mem_addr_o, mem_data_o, mem_wr_o, last_grant_o
    );

    modport master (
        output a_req_i, a_we_i, a_addr_i, a_wdata_i,
        output b_req_i, b_we_i, b_addr_i, b_wdata_i,
        output mem_data_i,
        input  a_ack_o, a_rdata_o, b_ack_o, b_rdata_o,
        input  mem_addr_o, mem_data_o, mem_wr_o, last_grant_o
    );

endinterface

// File: rtl/sram_port_arbiter_rr_arb2.sv
// Two-way arbiter: combinational one-hot grant (bit 0 = A, bit 1 = B) plus last-grant pointer.
// Ties go to the port not granted last, or always to A when FIXED_PRIO is set.
module rr_arb2
    import sram_arb_pkg::*;
#(
    parameter int FIXED_PRIO = 0
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       elig_a,
    input  logic       elig_b,
    output logic [1:0] grant,
    output port_id_t   last_grant
);

    logic [1:0] grant_s;
    port_id_t   last_r;

    // Grant selection from the eligible bits and the pointer.
    always_comb begin
        grant_s = 2'b00;
        if (elig_a && elig_b) begin
            if (FIXED_PRIO != 0) begin
                grant_s = 2'b01;
            end else if (last_r == PORT_B) begin
                grant_s = 2'b01;
            end else begin
                grant_s = 2'b10;
            end
        end else if (elig_a) begin
            grant_s = 2'b01;
        end else if (elig_b) begin
            grant_s = 2'b10;
        end else begin
            grant_s = 2'b00;
        end
    end

    // Pointer tracks the most recent grant; reset to B so A wins the first tie.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_r <= PORT_B;
        end else if (grant_s[0]) begin
            last_r <= PORT_A;
        end else if (grant_s[1]) begin
            last_r <= PORT_B;
        end else begin
            last_r <= last_r;
        end
    end

    assign grant      = grant_s;
    assign last_grant = last_r;

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-port synchronous SRAM between requester A and requester B.
// Grants are issued in the request cycle; all SRAM and requester outputs are registered.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W     = 6,
    parameter int DATA_W     = 32,
    parameter int FIXED_PRIO = 0
) (
    input logic                clk_i,
    input logic                rst_i,
    sram_port_arbiter_if.slave bus
);

    logic              pend_a_r;
    logic              pend_b_r;
    logic              elig_a_s;
    logic              elig_b_s;
    logic [1:0]        grant_s;
    port_id_t          last_grant_s;

    logic              any_grant_s;
    logic              sel_we_s;
    port_id_t          sel_port_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_wdata_s;

    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_data_r;
    logic              mem_wr_r;

    ret_entry_t [RET_DEPTH-1:0] ret_r;
    ret_entry_t        ret_out_s;

    logic              wr_ack_a_s;
    logic              wr_ack_b_s;
    logic              rd_ack_a_s;
    logic              rd_ack_b_s;
    logic              a_ack_r;
    logic              b_ack_r;
    logic [DATA_W-1:0] a_rdata_r;
    logic [DATA_W-1:0] b_rdata_r;

    // Pending stays set through the ack cycle, so a held req is not re-granted there.
    assign elig_a_s = bus.a_req_i & ~pend_a_r;
    assign elig_b_s = bus.b_req_i & ~pend_b_r;

    rr_arb2 #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_arb (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .elig_a     (elig_a_s),
        .elig_b     (elig_b_s),
        .grant      (grant_s),
        .last_grant (last_grant_s)
    );

    // Mux the granted port's transaction fields.
    always_comb begin
        any_grant_s = grant_s[0] | grant_s[1];
        sel_port_s  = PORT_A;
        sel_we_s    = bus.a_we_i;
        sel_addr_s  = bus.a_addr_i;
        sel_wdata_s = bus.a_wdata_i;
        if (grant_s[1]) begin
            sel_port_s  = PORT_B;
            sel_we_s    = bus.b_we_i;
            sel_addr_s  = bus.b_addr_i;
            sel_wdata_s = bus.b_wdata_i;
        end else begin
            sel_port_s  = PORT_A;
            sel_we_s    = bus.a_we_i;
            sel_addr_s  = bus.a_addr_i;
            sel_wdata_s = bus.a_wdata_i;
        end
    end

    // Completion sources: writes ack as they strobe, reads when the return pipe drains.
    always_comb begin
        ret_out_s  = ret_r[RET_DEPTH-1];
        wr_ack_a_s = any_grant_s & sel_we_s & (sel_port_s == PORT_A);
        wr_ack_b_s = any_grant_s & sel_we_s & (sel_port_s == PORT_B);
        rd_ack_a_s = ret_out_s.valid & (ret_out_s.port == PORT_A);
        rd_ack_b_s = ret_out_s.valid & (ret_out_s.port == PORT_B);
    end

    // Per-port pending flags.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pend_a_r <= 1'b0;
            pend_b_r <= 1'b0;
        end else begin
            if (grant_s[0]) begin
                pend_a_r <= 1'b1;
            end else if (a_ack_r) begin
                pend_a_r <= 1'b0;
            end else begin
                pend_a_r <= pend_a_r;
            end
            if (grant_s[1]) begin
                pend_b_r <= 1'b1;
            end else if (b_ack_r) begin
                pend_b_r <= 1'b0;
            end else begin
                pend_b_r <= pend_b_r;
            end
        end
    end

    // Issue stage toward the SRAM; address and data hold while idle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_addr_r <= {ADDR_W{1'b0}};
            mem_data_r <= {DATA_W{1'b0}};
            mem_wr_r   <= 1'b0;
        end else if (any_grant_s) begin
            mem_addr_r <= sel_addr_s;
            mem_wr_r   <= sel_we_s;
            if (sel_we_s) begin
                mem_data_r <= sel_wdata_s;
            end else begin
                mem_data_r <= mem_data_r;
            end
        end else begin
            mem_addr_r <= mem_addr_r;
            mem_data_r <= mem_data_r;
            mem_wr_r   <= 1'b0;
        end
    end

    // Return pipe: tags each read with its owner until the SRAM data arrives.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ret_r <= {(2 * RET_DEPTH){1'b0}};
        end else begin
            ret_r[0] <= '{valid: any_grant_s & ~sel_we_s, port: sel_port_s};
            for (int i = 1; i < RET_DEPTH; i++) begin
                ret_r[i] <= ret_r[i-1];
            end
        end
    end

    // Ack pulses and per-port read data capture.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a_ack_r   <= 1'b0;
            b_ack_r   <= 1'b0;
            a_rdata_r <= {DATA_W{1'b0}};
            b_rdata_r <= {DATA_W{1'b0}};
        end else begin
            a_ack_r <= wr_ack_a_s | rd_ack_a_s;
            b_ack_r <= wr_ack_b_s | rd_ack_b_s;
            if (rd_ack_a_s) begin
                a_rdata_r <= bus.mem_data_i;
            end else begin
                a_rdata_r <= a_rdata_r;
            end
            if (rd_ack_b_s) begin
                b_rdata_r <= bus.mem_data_i;
            end else begin
                b_rdata_r <= b_rdata_r;
            end
        end
    end

    assign bus.mem_addr_o   = mem_addr_r;
    assign bus.mem_data_o   = mem_data_r;
    assign bus.mem_wr_o     = mem_wr_r;
    assign bus.a_ack_o      = a_ack_r;
    assign bus.b_ack_o      = b_ack_r;
    assign bus.a_rdata_o    = a_rdata_r;
    assign bus.b_rdata_o    = b_rdata_r;
    assign bus.last_grant_o = last_grant_s;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: directed table, hand-written corner sequences on a
// round-robin and a fixed-priority instance, then random traffic against a transaction model.
module tb_sram_port_arbiter;
    import sram_arb_pkg::*;

    localparam int AW = 6;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst0;
    logic rst1;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    sram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus0 ();
    sram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();

    sram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(0)) dut0 (
        .clk_i (clk), .rst_i (rst0), .bus (bus0));
    sram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(1)) dut1 (
        .clk_i (clk), .rst_i (rst1), .bus (bus1));

    // Synchronous SRAM models: data appears one cycle after the address.
    logic [DW-1:0] sram0 [64];
    logic [DW-1:0] sram1 [64];
    always @(posedge clk) begin
        if (bus0.mem_wr_o) sram0[bus0.mem_addr_o] <= bus0.mem_data_o;
        bus0.mem_data_i <= sram0[bus0.mem_addr_o];
        if (bus1.mem_wr_o) sram1[bus1.mem_addr_o] <= bus1.mem_data_o;
        bus1.mem_data_i <= sram1[bus1.mem_addr_o];
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        bit          port;
        bit          we;
        logic [5:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        int          exp_lat;
    } vec_t;

    vec_t        tbl [12];
    logic [31:0] last_wd0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic chk_rng(input string name, input int got, input int lo, input int hi);
        n_vec++;
        if (got < lo || got > hi) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, got, lo, hi);
        end
    endtask

    task automatic drv0(input bit p, input bit req, input bit we,
                        input logic [5:0] addr, input logic [31:0] wd);
        if (p == 1'b0) begin
            bus0.a_req_i = req; bus0.a_we_i = we; bus0.a_addr_i = addr; bus0.a_wdata_i = wd;
        end else begin
            bus0.b_req_i = req; bus0.b_we_i = we; bus0.b_addr_i = addr; bus0.b_wdata_i = wd;
        end
    endtask

    task automatic drv1(input bit p, input bit req, input bit we,
                        input logic [5:0] addr, input logic [31:0] wd);
        if (p == 1'b0) begin
            bus1.a_req_i = req; bus1.a_we_i = we; bus1.a_addr_i = addr; bus1.a_wdata_i = wd;
        end else begin
            bus1.b_req_i = req; bus1.b_we_i = we; bus1.b_addr_i = addr; bus1.b_wdata_i = wd;
        end
    endtask

    // One isolated transaction on instance 0; latency counted from the request cycle.
    task automatic run_vec(input vec_t v, input int idx);
        int lat = -1;
        bit other_ack = 1'b0;
        @(posedge clk); #1;
        drv0(v.port, 1'b1, v.we, v.addr, v.wdata);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if ((v.port ? bus0.a_ack_o : bus0.b_ack_o) == 1'b1) other_ack = 1'b1;
            if ((v.port ? bus0.b_ack_o : bus0.a_ack_o) == 1'b1) begin
                lat = c;
                break;
            end
        end
        if (lat < 0) begin
            n_vec++; n_err++;
            $display("FAIL vec%0d timeout: got no ack expected ack within 8 cycles", idx);
        end else begin
            chk_rng($sformatf("vec%0d latency", idx), lat, v.exp_lat, v.exp_lat);
            if (v.we) begin
                chk($sformatf("vec%0d mem_wr", idx), 32'(bus0.mem_wr_o), 32'd1);
                chk($sformatf("vec%0d mem_addr", idx), 32'(bus0.mem_addr_o), 32'(v.addr));
                chk($sformatf("vec%0d mem_data", idx), bus0.mem_data_o, v.wdata);
                last_wd0 = v.wdata;
            end else begin
                chk($sformatf("vec%0d rdata", idx), v.port ? bus0.b_rdata_o : bus0.a_rdata_o,
                    v.exp_rdata);
                chk($sformatf("vec%0d mem_data hold", idx), bus0.mem_data_o, last_wd0);
            end
        end
        chk($sformatf("vec%0d other ack", idx), 32'(other_ack), 32'd0);
        @(posedge clk); #1;
        drv0(v.port, 1'b0, 1'b0, 6'h00, 32'h0);
    endtask

    // Random-phase state: one outstanding transaction per port, modelled at transaction level.
    bit          busy [2];
    bit          q_we [2];
    logic [5:0]  q_addr [2];
    logic [31:0] q_wd [2];
    int          q_start [2];
    bit          have_rd [2];
    logic [31:0] last_rd [2];
    logic [31:0] ref_mem [64];
    bit          known [64];

    initial begin
        bit          ord [$];
        int          a_lat;
        bit          seen;
        bit          wr_ack;
        bit          have_wd;
        logic [31:0] rnd_wd;

        rst0 = 1'b1;
        rst1 = 1'b1;
        drv0(1'b0, 1'b0, 1'b0, 6'h00, 32'h0); drv0(1'b1, 1'b0, 1'b0, 6'h00, 32'h0);
        drv1(1'b0, 1'b0, 1'b0, 6'h00, 32'h0); drv1(1'b1, 1'b0, 1'b0, 6'h00, 32'h0);
        last_wd0 = 32'h0;
        tbl[0]  = '{1'b0, 1'b1, 6'h05, 32'hDEADBEEF, 32'h0,        1};
        tbl[1]  = '{1'b0, 1'b0, 6'h05, 32'h0,        32'hDEADBEEF, 3};
        tbl[2]  = '{1'b1, 1'b1, 6'h3F, 32'h0BADF00D, 32'h0,        1};
        tbl[3]  = '{1'b1, 1'b0, 6'h3F, 32'h0,        32'h0BADF00D, 3};
        tbl[4]  = '{1'b0, 1'b0, 6'h3F, 32'h0,        32'h0BADF00D, 3};
        tbl[5]  = '{1'b1, 1'b1, 6'h00, 32'hA5A5A5A5, 32'h0,        1};
        tbl[6]  = '{1'b0, 1'b0, 6'h00, 32'h0,        32'hA5A5A5A5, 3};
        tbl[7]  = '{1'b0, 1'b1, 6'h3F, 32'hFFFFFFFF, 32'h0,        1};
        tbl[8]  = '{1'b1, 1'b0, 6'h3F, 32'h0,        32'hFFFFFFFF, 3};
        tbl[9]  = '{1'b0, 1'b1, 6'h01, 32'h11111111, 32'h0,        1};
        tbl[10] = '{1'b1, 1'b1, 6'h02, 32'h22222222, 32'h0,        1};
        tbl[11] = '{1'b1, 1'b0, 6'h05, 32'h0,        32'hDEADBEEF, 3};

        repeat (3) @(posedge clk);
        #1;
        rst0 = 1'b0;
        rst1 = 1'b0;

        for (int i = 0; i < 12; i++) run_vec(tbl[i], i);

        // Reset held 3 cycles with both requests up, then continuous round-robin reads.
        @(posedge clk); #1;
        rst0 = 1'b1;
        drv0(1'b0, 1'b1, 1'b0, 6'h01, 32'h0);
        drv0(1'b1, 1'b1, 1'b0, 6'h02, 32'h0);
        @(negedge clk);
        for (int r = 0; r < 3; r++) begin
            @(posedge clk); #1;
            if (r == 2) rst0 = 1'b0;
            @(negedge clk);
            chk($sformatf("rst%0d a_ack", r), 32'(bus0.a_ack_o), 32'd0);
            chk($sformatf("rst%0d b_ack", r), 32'(bus0.b_ack_o), 32'd0);
            chk($sformatf("rst%0d a_rdata", r), bus0.a_rdata_o, 32'h0);
            chk($sformatf("rst%0d b_rdata", r), bus0.b_rdata_o, 32'h0);
            chk($sformatf("rst%0d mem_addr", r), 32'(bus0.mem_addr_o), 32'd0);
            chk($sformatf("rst%0d mem_data", r), bus0.mem_data_o, 32'h0);
            chk($sformatf("rst%0d mem_wr", r), 32'(bus0.mem_wr_o), 32'd0);
        end
        chk("rst pointer", 32'(bus0.last_grant_o), 32'(PORT_B));
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 1) chk("rr first addr", 32'(bus0.mem_addr_o), 32'h01);
            if (c == 2) chk("rr second addr", 32'(bus0.mem_addr_o), 32'h02);
            if (c == 3) chk("rr first ack cycle", 32'(bus0.a_ack_o), 32'd1);
            if (bus0.a_ack_o) begin
                ord.push_back(1'b0);
                chk("rr a_rdata", bus0.a_rdata_o, 32'h11111111);
            end
            if (bus0.b_ack_o) begin
                ord.push_back(1'b1);
                chk("rr b_rdata", bus0.b_rdata_o, 32'h22222222);
            end
        end
        chk("rr ack count", 32'(ord.size()), 32'd6);
        for (int i = 0; i < ord.size() && i < 6; i++)
            chk($sformatf("rr order%0d", i), 32'(ord[i]), 32'(i % 2));
        @(posedge clk); #1;
        drv0(1'b0, 1'b0, 1'b0, 6'h00, 32'h0);
        drv0(1'b1, 1'b0, 1'b0, 6'h00, 32'h0);
        repeat (6) @(negedge clk);

        // Coherency: B writes, A reads the same word one cycle after B's grant.
        @(posedge clk); #1;
        drv0(1'b1, 1'b1, 1'b1, 6'h3F, 32'h12345678);
        @(posedge clk); #1;
        drv0(1'b0, 1'b1, 1'b0, 6'h3F, 32'h0);
        @(negedge clk);
        chk("coh b_ack", 32'(bus0.b_ack_o), 32'd1);
        chk("coh mem_wr", 32'(bus0.mem_wr_o), 32'd1);
        @(posedge clk); #1;
        drv0(1'b1, 1'b0, 1'b0, 6'h00, 32'h0);
        a_lat = -1;
        for (int c = 2; c < 9; c++) begin
            @(negedge clk);
            if (bus0.a_ack_o) begin
                a_lat = c;
                break;
            end
        end
        chk_rng("coh a_ack cycle", a_lat, 4, 4);
        chk("coh a_rdata", bus0.a_rdata_o, 32'h12345678);
        @(posedge clk); #1;
        drv0(1'b0, 1'b0, 1'b0, 6'h00, 32'h0);
        @(negedge clk);

        // Reset pulse in the cycle after an A read grant discards the read.
        @(posedge clk); #1;
        drv0(1'b0, 1'b1, 1'b0, 6'h05, 32'h0);
        @(posedge clk); #1;
        rst0 = 1'b1;
        drv0(1'b0, 1'b0, 1'b0, 6'h00, 32'h0);
        @(posedge clk); #1;
        rst0 = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (bus0.a_ack_o) seen = 1'b1;
        end
        chk("midrst no ack", 32'(seen), 32'd0);
        chk("midrst a_rdata", bus0.a_rdata_o, 32'h0);
        last_wd0 = 32'h0;
        run_vec('{1'b0, 1'b0, 6'h05, 32'h0, 32'hDEADBEEF, 3}, 12);

        // A alone, then a tie: round-robin favours B, fixed priority favours A.
        @(posedge clk); #1;
        drv0(1'b0, 1'b1, 1'b1, 6'h10, 32'hA0A0A0A0);
        drv1(1'b0, 1'b1, 1'b1, 6'h10, 32'hA0A0A0A0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("prio0 solo ack", 32'(bus0.a_ack_o), 32'd1);
        chk("prio1 solo ack", 32'(bus1.a_ack_o), 32'd1);
        @(posedge clk); #1;
        drv0(1'b0, 1'b1, 1'b1, 6'h11, 32'hA1A1A1A1);
        drv0(1'b1, 1'b1, 1'b1, 6'h31, 32'hB1B1B1B1);
        drv1(1'b0, 1'b1, 1'b1, 6'h11, 32'hA1A1A1A1);
        drv1(1'b1, 1'b1, 1'b1, 6'h31, 32'hB1B1B1B1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rr tie b_ack", 32'(bus0.b_ack_o), 32'd1);
        chk("rr tie a_ack", 32'(bus0.a_ack_o), 32'd0);
        chk("rr tie addr", 32'(bus0.mem_addr_o), 32'h31);
        chk("fp tie a_ack", 32'(bus1.a_ack_o), 32'd1);
        chk("fp tie b_ack", 32'(bus1.b_ack_o), 32'd0);
        chk("fp tie addr", 32'(bus1.mem_addr_o), 32'h11);
        @(posedge clk); #1;
        drv0(1'b1, 1'b0, 1'b0, 6'h00, 32'h0);
        drv1(1'b0, 1'b0, 1'b0, 6'h00, 32'h0);
        @(negedge clk);
        chk("rr next a_ack", 32'(bus0.a_ack_o), 32'd1);
        chk("rr next addr", 32'(bus0.mem_addr_o), 32'h11);
        chk("fp next b_ack", 32'(bus1.b_ack_o), 32'd1);
        chk("fp next addr", 32'(bus1.mem_addr_o), 32'h31);
        chk("fp next data", bus1.mem_data_o, 32'hB1B1B1B1);
        @(posedge clk); #1;
        drv0(1'b0, 1'b0, 1'b0, 6'h00, 32'h0);
        drv1(1'b1, 1'b0, 1'b0, 6'h00, 32'h0);
        repeat (2) @(negedge clk);

        // Random traffic: A owns addresses 0x00-0x07, B owns 0x20-0x27.
        for (int i = 0; i < 64; i++) known[i] = 1'b0;
        for (int p = 0; p < 2; p++) begin
            busy[p] = 1'b0;
            have_rd[p] = 1'b0;
        end
        have_wd = 1'b0;
        rnd_wd = 32'h0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clk); #1;
            for (int p = 0; p < 2; p++) begin
                if (!busy[p]) begin
                    if ($urandom_range(0, 3) != 0) begin
                        busy[p]    = 1'b1;
                        q_we[p]    = 1'($urandom_range(0, 1));
                        q_addr[p]  = {1'(p), 2'b00, 3'($urandom_range(0, 7))};
                        q_wd[p]    = $urandom;
                        q_start[p] = cyc;
                        drv0(1'(p), 1'b1, q_we[p], q_addr[p], q_wd[p]);
                    end else begin
                        drv0(1'(p), 1'b0, 1'b0, 6'h00, 32'h0);
                    end
                end
            end
            @(negedge clk);
            wr_ack = 1'b0;
            for (int p = 0; p < 2; p++) begin
                logic        ack;
                logic [31:0] rd;
                ack = (p == 0) ? bus0.a_ack_o : bus0.b_ack_o;
                rd  = (p == 0) ? bus0.a_rdata_o : bus0.b_rdata_o;
                if (ack) begin
                    if (!busy[p]) begin
                        n_vec++; n_err++;
                        $display("FAIL rnd spurious ack port %0d: got ack expected none", p);
                    end else begin
                        busy[p] = 1'b0;
                        if (q_we[p]) begin
                            wr_ack = 1'b1;
                            chk_rng("rnd wr latency", cyc - q_start[p], 1, 2);
                            chk("rnd wr addr", 32'(bus0.mem_addr_o), 32'(q_addr[p]));
                            chk("rnd wr data", bus0.mem_data_o, q_wd[p]);
                            ref_mem[q_addr[p]] = q_wd[p];
                            known[q_addr[p]] = 1'b1;
                            rnd_wd = q_wd[p];
                            have_wd = 1'b1;
                        end else begin
                            chk_rng("rnd rd latency", cyc - q_start[p], 3, 4);
                            if (known[q_addr[p]]) chk("rnd rdata", rd, ref_mem[q_addr[p]]);
                            last_rd[p] = rd;
                            have_rd[p] = 1'b1;
                        end
                    end
                end else begin
                    if (have_rd[p]) chk("rnd rdata stable", rd, last_rd[p]);
                    if (busy[p] && (cyc - q_start[p] > 6)) begin
                        n_vec++; n_err++;
                        $display("FAIL rnd timeout port %0d: got no ack expected within 6 cycles", p);
                        busy[p] = 1'b0;
                    end
                end
            end
            chk("rnd mem_wr", 32'(bus0.mem_wr_o), 32'(wr_ack));
            if (have_wd && !wr_ack) chk("rnd mem_data hold", bus0.mem_data_o, rnd_wd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Two-requester arbiter that shares one single-port synchronous SRAM bus (address, write data, read data, write strobe) between a host-side register-bus master (port A) and a hardware-side engine (port B). Each requester gets a simple req/ack transaction interface with one transaction outstanding at a time. The arbiter issues at most one SRAM access per cycle, returns read data to the right requester after the fixed SRAM read latency, and arbitrates round-robin, or with fixed priority to A when configured. It sits between the register-bus glue and the SRAM macro in place of a direct bus-to-memory connection.

## Interface
Parameters:
- ADDR_W, 6, SRAM word-address width
- DATA_W, 32, data width
- FIXED_PRIO, 0, 0 = round-robin; 1 = A always wins a simultaneous request

Ports:
- clk_i  in  1  sole clock, all logic on its rising edge
- rst_i  in  1  reset, synchronous, active-high
- a_req_i / b_req_i  in  1  request; held with its fields until ack
- a_we_i / b_we_i  in  1  1 = write, 0 = read
- a_addr_i / b_addr_i  in  ADDR_W  word address
- a_wdata_i / b_wdata_i  in  DATA_W  write data
- a_ack_o / b_ack_o  out  1  one-cycle completion pulse
- a_rdata_o / b_rdata_o  out  DATA_W  read data, valid when ack is high for a read
- mem_addr_o  out  ADDR_W  SRAM address (registered)
- mem_data_o  out  DATA_W  SRAM write data (registered)
- mem_wr_o  out  1  SRAM write strobe (registered)
- mem_data_i  in  DATA_W  SRAM read data; valid one cycle after the address is presented

## Operation
- Per-port pending flag:
  - set on grant, cleared in that port's ack cycle;
  - a port is eligible when req & ~pending;
  - a request still asserted during its own ack cycle is not re-granted.
- Grant rules (evaluated every cycle):
  - no eligible port: idle, mem_wr_o = 0, mem_addr_o and mem_data_o hold their last values;
  - one eligible port: grant it;
  - both eligible, FIXED_PRIO = 0: grant the port not granted last. The last-grant pointer resets to B, so A wins the first tie;
  - both eligible, FIXED_PRIO = 1: grant A.
- Issue stage, registered on the cycle after the grant:
  - mem_addr_o takes the granted port's address;
  - mem_wr_o = granted we;
  - mem_data_o takes the granted port's wdata on a write and holds otherwise.
- Read return:
  - a 2-deep shift register carries {valid, port id} alongside the access;
  - when mem_data_i is valid, it is registered into the owning port's rdata, and that port's ack pulses.
- rdata of a port changes only on that port's read completion.
- Requester contract: it deasserts req or presents a new transaction on the cycle after ack. Changing fields while pending is illegal and unchecked.

## Timing
Request eligible in cycle N, granted in cycle N:
- Write: mem_wr_o/mem_addr_o/mem_data_o valid in N+1; ack in N+1; SRAM commits at the end of N+1.
- Read: mem_addr_o valid in N+1; mem_data_i valid in N+2; rdata and ack in N+3.
- Same port re-eligible the cycle after its ack. Peak per-port rate: 1 write per 2 cycles, 1 read per 4 cycles.
- SRAM issue rate: up to 1 access per cycle, with ports interleaved.
- Ordering: accesses hit the SRAM in grant order. A write granted in N is visible to a read granted in N+1 or later, from either port.
- Acks for A and B can coincide, e.g. a write ack and a read ack landing in the same cycle.
- Reset, held in any cycle:
  - all outputs to 0: mem_addr_o, mem_data_o, mem_wr_o, both ack, both rdata;
  - pending flags and return pipe cleared, pointer set to B;
  - in-flight reads are discarded with no ack; a write not yet strobed is dropped.
  - First grant possible in the first cycle after rst_i deasserts.

## Structure
- Shared package sram_arb_pkg holds:
  - typedef port_id_t (PORT_A = 0, PORT_B = 1);
  - constants RD_LAT = 1 (SRAM read latency) and RET_DEPTH = RD_LAT + 1 (return-pipe depth).
- Sub-module rr_arb2:
  - inputs: two eligible bits, FIXED_PRIO;
  - outputs: one-hot grant and the last-grant pointer register.
- Top level holds the pending flags, the issue registers, the return pipe and the rdata registers.

## Test plan
- Reset: drive rst_i for 3 cycles with both req high -> every output 0 throughout, no mem_wr_o; the first grant occurs the cycle after release.
- A writes addr 0x05 data 0xDEADBEEF in N -> mem_wr_o = 1, mem_addr_o = 0x05, mem_data_o = 0xDEADBEEF, a_ack_o all in N+1. A then reads 0x05 -> a_ack_o 3 cycles after its grant with a_rdata_o = 0xDEADBEEF; b_ack_o stays 0.
- Round-robin (FIXED_PRIO = 0): both ports issue continuous reads of 0x01 (A) and 0x02 (B) from reset -> grants go A, B, A, B. SRAM addresses alternate 0x01/0x02, and each ack carries its own port's data.
- Fixed priority (FIXED_PRIO = 1): A and B request in the same cycle -> A granted first. B is granted the next cycle, because A is pending, and is never starved.
- Coherency: B writes 0x3F data 0x12345678, and A reads 0x3F, requested the cycle after B's grant -> a_rdata_o = 0x12345678.
- Reset mid-read: pulse rst_i for 1 cycle in N+1 of an A read -> no a_ack_o, a_rdata_o = 0. A new A read issued after reset completes normally.
